// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light phase controller and its output/LCD stage:
// phase, lamp and phrase codes plus the duration-clamping and lamp-decoding helpers.
package traffic_pkg;

    typedef enum logic [1:0] {
        PG = 2'd0,
        PY = 2'd1,
        SG = 2'd2,
        SY = 2'd3
    } phase_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_AMB = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [1:0] PED_RED  = 2'b10;
    localparam logic [1:0] PED_GRN  = 2'b01;

    localparam logic [1:0] PHR_PRI = 2'd0;
    localparam logic [1:0] PHR_SEC = 2'd1;
    localparam logic [1:0] PHR_PED = 2'd2;
    localparam logic [1:0] PHR_ERR = 2'd3;

    typedef struct packed {
        logic       err;
        logic [6:0] val;
    } load_t;

    typedef struct packed {
        logic [2:0] pri;
        logic [2:0] sec;
        logic [1:0] ped_p;
        logic [1:0] ped_s;
    } lamps_t;

    // Out-of-range durations are forced into 1..max_t and flagged as a configuration error.
    function automatic load_t clamp_time(input logic [6:0] x, input logic [6:0] max_t);
        load_t r;
        if (x == 7'd0) begin
            r = '{err: 1'b1, val: 7'd1};
        end else if (x > max_t) begin
            r = '{err: 1'b1, val: max_t};
        end else begin
            r = '{err: 1'b0, val: x};
        end
        return r;
    endfunction

    function automatic lamps_t lamps_of(input phase_t ph);
        lamps_t r;
        case (ph)
            PG:      r = '{pri: LAMP_GRN, sec: LAMP_RED, ped_p: PED_RED, ped_s: PED_GRN};
            PY:      r = '{pri: LAMP_AMB, sec: LAMP_RED, ped_p: PED_RED, ped_s: PED_RED};
            SG:      r = '{pri: LAMP_RED, sec: LAMP_GRN, ped_p: PED_GRN, ped_s: PED_RED};
            SY:      r = '{pri: LAMP_RED, sec: LAMP_AMB, ped_p: PED_RED, ped_s: PED_RED};
            default: r = '{pri: LAMP_RED, sec: LAMP_RED, ped_p: PED_RED, ped_s: PED_RED};
        endcase
        return r;
    endfunction

    function automatic logic [1:0] phrase_of(input logic err, input logic pend, input phase_t ph);
        logic [1:0] r;
        if (err) begin
            r = PHR_ERR;
        end else if (pend) begin
            r = PHR_PED;
        end else if ((ph == PG) || (ph == PY)) begin
            r = PHR_PRI;
        end else begin
            r = PHR_SEC;
        end
        return r;
    endfunction

endpackage

// File: rtl/second_prescaler.sv
// Divides the system clock down to a one-cycle pulse per second.
module second_prescaler #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic clock50MHz,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_r;

    // Free-running 0..TICKS_PER_SEC-1 counter, cleared by reset.
    always_ff @(posedge clock50MHz) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/traffic_phase_controller.sv
// Four-phase crossing sequencer: countdown, pedestrian truncation and registered
// lamp / phrase codes for the output stage.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MIN_GREEN     = 5,
    parameter int MAX_TIME      = 99
) (
    input  logic       clock50MHz,
    input  logic       reset,
    input  logic [6:0] Tpv,
    input  logic [6:0] Tsv,
    input  logic [6:0] Ta,
    input  logic       ped_req_p,
    input  logic       ped_req_s,
    output logic [1:0] StateFlag,
    output logic [1:0] PhraseSel,
    output logic [6:0] timeRemaining,
    output logic [2:0] Principal_Road,
    output logic [2:0] Secondary_Road,
    output logic [1:0] Principal_Pedestrian,
    output logic [1:0] Secondary_Pedestrian
);

    localparam logic [6:0] MIN_T = 7'(MIN_GREEN);
    localparam logic [6:0] MAX_T = 7'(MAX_TIME);

    logic       tick_s;
    phase_t     state_r, state_s;
    logic [6:0] time_r, time_s;
    logic       pend_p_r, pend_p_s, pend_s_r, pend_s_s;
    logic       cfg_err_r, cfg_err_s;
    logic [1:0] phrase_r, phrase_s;
    lamps_t     lamps_r, lamps_s;
    load_t      pv_s, sv_s, a_s, ld_s;
    logic       req_p_s, req_s_s, trunc_s;

    second_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clock50MHz(clock50MHz),
        .reset     (reset),
        .tick      (tick_s)
    );

    // Next-phase, countdown, request and output-code computation.
    always_comb begin
        pv_s      = clamp_time(Tpv, MAX_T);
        sv_s      = clamp_time(Tsv, MAX_T);
        a_s       = clamp_time(Ta, MAX_T);
        state_s   = state_r;
        time_s    = time_r;
        cfg_err_s = cfg_err_r;
        ld_s      = pv_s;
        // A request raised this cycle already counts as pending for truncation.
        req_p_s   = pend_p_r | ped_req_p;
        req_s_s   = pend_s_r | ped_req_s;
        trunc_s   = (time_r > MIN_T) &&
                    (((state_r == PG) && req_p_s) || ((state_r == SG) && req_s_s));
        if (trunc_s) begin
            time_s = MIN_T;
        end else if (tick_s) begin
            if (time_r > 7'd1) begin
                time_s = time_r - 7'd1;
            end else begin
                case (state_r)
                    PG:      begin state_s = PY; ld_s = a_s;  end
                    PY:      begin state_s = SG; ld_s = sv_s; end
                    SG:      begin state_s = SY; ld_s = a_s;  end
                    SY:      begin state_s = PG; ld_s = pv_s; end
                    default: begin state_s = PG; ld_s = pv_s; end
                endcase
                time_s    = ld_s.val;
                cfg_err_s = ld_s.err;
            end
        end else begin
            time_s = time_r;
        end
        pend_p_s = ped_req_p | (pend_p_r & ~((state_s == SG) && (state_r != SG)));
        pend_s_s = ped_req_s | (pend_s_r & ~((state_s == PG) && (state_r != PG)));
        phrase_s = phrase_of(cfg_err_s, pend_p_s | pend_s_s, state_s);
        lamps_s  = lamps_of(state_s);
    end

    // State and registered outputs; reset overrides any tick or request on the same edge.
    always_ff @(posedge clock50MHz) begin
        if (!reset) begin
            state_r   <= PG;
            time_r    <= pv_s.val;
            pend_p_r  <= 1'b0;
            pend_s_r  <= 1'b0;
            cfg_err_r <= 1'b0;
            phrase_r  <= PHR_PRI;
            lamps_r   <= lamps_of(PG);
        end else begin
            state_r   <= state_s;
            time_r    <= time_s;
            pend_p_r  <= pend_p_s;
            pend_s_r  <= pend_s_s;
            cfg_err_r <= cfg_err_s;
            phrase_r  <= phrase_s;
            lamps_r   <= lamps_s;
        end
    end

    assign StateFlag            = state_r;
    assign PhraseSel            = phrase_r;
    assign timeRemaining        = time_r;
    assign Principal_Road       = lamps_r.pri;
    assign Secondary_Road       = lamps_r.sec;
    assign Principal_Pedestrian = lamps_r.ped_p;
    assign Secondary_Pedestrian = lamps_r.ped_s;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller: directed scenarios plus a randomized
// run compared against a seconds-level reference model of the crossing.
module tb_traffic_phase_controller;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] Tpv, Tsv, Ta;
    logic       ped_req_p, ped_req_s;
    logic [1:0] StateFlag, PhraseSel;
    logic [6:0] timeRemaining;
    logic [2:0] Principal_Road, Secondary_Road;
    logic [1:0] Principal_Pedestrian, Secondary_Pedestrian;
    logic [20:0] act_vec;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase index 0..3, seconds left, position within the second.
    int m_phase, m_time, m_presc;
    bit m_pp, m_ps, m_err;

    logic [2:0] exp_pr [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    logic [2:0] exp_sr [4] = '{3'b100, 3'b100, 3'b001, 3'b010};
    logic [1:0] exp_pp [4] = '{2'b10, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_sp [4] = '{2'b01, 2'b10, 2'b10, 2'b10};

    always #5 clk = ~clk;

    traffic_phase_controller #(
        .TICKS_PER_SEC(TPS),
        .MIN_GREEN    (5),
        .MAX_TIME     (99)
    ) dut (
        .clock50MHz          (clk),
        .reset               (reset),
        .Tpv                 (Tpv),
        .Tsv                 (Tsv),
        .Ta                  (Ta),
        .ped_req_p           (ped_req_p),
        .ped_req_s           (ped_req_s),
        .StateFlag           (StateFlag),
        .PhraseSel           (PhraseSel),
        .timeRemaining       (timeRemaining),
        .Principal_Road      (Principal_Road),
        .Secondary_Road      (Secondary_Road),
        .Principal_Pedestrian(Principal_Pedestrian),
        .Secondary_Pedestrian(Secondary_Pedestrian)
    );

    assign act_vec = {StateFlag, PhraseSel, timeRemaining, Principal_Road, Secondary_Road,
                      Principal_Pedestrian, Secondary_Pedestrian};

    function automatic int clampv(input int x);
        return (x == 0) ? 1 : ((x > 99) ? 99 : x);
    endfunction

    function automatic void model_step();
        bit tick, rp, rs;
        int entered, dur;
        if (!reset) begin
            m_phase = 0; m_time = clampv(int'(Tpv)); m_presc = 0;
            m_pp = 0; m_ps = 0; m_err = 0;
            return;
        end
        tick    = (m_presc == TPS - 1);
        m_presc = tick ? 0 : m_presc + 1;
        rp      = m_pp || ped_req_p;
        rs      = m_ps || ped_req_s;
        entered = -1;
        if (((m_phase == 0 && rp) || (m_phase == 2 && rs)) && m_time > 5) begin
            m_time = 5;
        end else if (tick) begin
            if (m_time > 1) begin
                m_time = m_time - 1;
            end else begin
                m_phase = (m_phase + 1) % 4;
                dur     = (m_phase % 2 == 1) ? int'(Ta) : ((m_phase == 2) ? int'(Tsv) : int'(Tpv));
                m_time  = clampv(dur);
                m_err   = (dur == 0) || (dur > 99);
                entered = m_phase;
            end
        end
        m_pp = ped_req_p || (m_pp && entered != 2);
        m_ps = ped_req_s || (m_ps && entered != 0);
    endfunction

    function automatic logic [20:0] exp_vec();
        logic [1:0] phr;
        if (m_err) phr = 2'd3;
        else if (m_pp || m_ps) phr = 2'd2;
        else if (m_phase < 2) phr = 2'd0;
        else phr = 2'd1;
        return {2'(m_phase), phr, 7'(m_time), exp_pr[m_phase], exp_sr[m_phase],
                exp_pp[m_phase], exp_sp[m_phase]};
    endfunction

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; Tpv = 7'd8; Tsv = 7'd6; Ta = 7'd3;
        ped_req_p = 1'b0; ped_req_s = 1'b0;
        advance();
        advance();
        n_cmp++; if (StateFlag !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", StateFlag); end
        n_cmp++; if (timeRemaining !== 7'd8) begin n_err++; $display("FAIL reset_time: got %0d want 8", timeRemaining); end
        n_cmp++; if (PhraseSel !== 2'd0) begin n_err++; $display("FAIL reset_phrase: got %0d want 0", PhraseSel); end
        n_cmp++; if ({Principal_Road, Secondary_Road} !== 6'b001_100) begin n_err++; $display("FAIL reset_roads: got %b want 001100", {Principal_Road, Secondary_Road}); end
        n_cmp++; if ({Principal_Pedestrian, Secondary_Pedestrian} !== 4'b10_01) begin n_err++; $display("FAIL reset_peds: got %b want 1001", {Principal_Pedestrian, Secondary_Pedestrian}); end
        reset = 1'b1;
    endtask

    task automatic test_sequence();
        int want_ph [4] = '{1, 2, 3, 0};
        int want_n  [4] = '{32, 12, 24, 12};
        int want_t  [4] = '{3, 6, 3, 8};
        for (int k = 0; k < 4; k++) begin
            int n;
            logic [1:0] cur;
            cur = StateFlag;
            n = 0;
            while (StateFlag == cur && n < 200) begin advance(); n++; end
            n_cmp++; if (n != want_n[k]) begin n_err++; $display("FAIL seq_cycles[%0d]: got %0d want %0d", k, n, want_n[k]); end
            n_cmp++; if (StateFlag !== 2'(want_ph[k])) begin n_err++; $display("FAIL seq_phase[%0d]: got %0d want %0d", k, StateFlag, want_ph[k]); end
            n_cmp++; if (timeRemaining !== 7'(want_t[k])) begin n_err++; $display("FAIL seq_time[%0d]: got %0d want %0d", k, timeRemaining, want_t[k]); end
        end
    endtask

    task automatic test_lamps();
        for (int i = 0; i < 160; i++) begin
            advance();
            n_cmp++; if (act_vec !== exp_vec()) begin n_err++; $display("FAIL lamps_vec cyc %0d: got %h want %h", i, act_vec, exp_vec()); end
            n_cmp++; if (Principal_Road != 3'b100 && Secondary_Road != 3'b100) begin n_err++; $display("FAIL both_roads_open cyc %0d: got %b/%b want one red", i, Principal_Road, Secondary_Road); end
            n_cmp++; if ((Principal_Pedestrian == 2'b01 && Principal_Road != 3'b100) ||
                         (Secondary_Pedestrian == 2'b01 && Secondary_Road != 3'b100)) begin
                n_err++; $display("FAIL ped_conflict cyc %0d: got %b%b%b%b want no conflict", i,
                                  Principal_Road, Principal_Pedestrian, Secondary_Road, Secondary_Pedestrian);
            end
        end
    endtask

    task automatic test_truncation();
        for (int i = 0; i < 400; i++) begin
            if (StateFlag == 2'd0 && timeRemaining == 7'd7) break;
            advance();
        end
        n_cmp++; if (!(StateFlag == 2'd0 && timeRemaining == 7'd7)) begin n_err++; $display("FAIL trunc_wait: got %0d/%0d want PG/7", StateFlag, timeRemaining); end
        ped_req_p = 1'b1;
        advance();
        ped_req_p = 1'b0;
        n_cmp++; if (timeRemaining !== 7'd5) begin n_err++; $display("FAIL trunc_time: got %0d want 5", timeRemaining); end
        n_cmp++; if (PhraseSel !== 2'd2) begin n_err++; $display("FAIL trunc_phrase: got %0d want 2", PhraseSel); end
        for (int i = 0; i < 200 && StateFlag != 2'd1; i++) advance();
        n_cmp++; if (PhraseSel !== 2'd2) begin n_err++; $display("FAIL trunc_py_phrase: got %0d want 2", PhraseSel); end
        for (int i = 0; i < 200 && StateFlag != 2'd2; i++) advance();
        n_cmp++; if (StateFlag !== 2'd2 || PhraseSel !== 2'd1) begin n_err++; $display("FAIL trunc_sg_clear: got %0d/%0d want 2/1", StateFlag, PhraseSel); end
    endtask

    task automatic test_no_truncation();
        int seen[$];
        for (int i = 0; i < 400; i++) begin
            if (StateFlag == 2'd0 && timeRemaining == 7'd4) break;
            advance();
        end
        ped_req_p = 1'b1;
        advance();
        ped_req_p = 1'b0;
        n_cmp++; if (timeRemaining !== 7'd4) begin n_err++; $display("FAIL notrunc_time: got %0d want 4", timeRemaining); end
        seen.push_back(int'(timeRemaining));
        for (int i = 0; i < 100 && StateFlag == 2'd0; i++) begin
            advance();
            if (StateFlag == 2'd0 && int'(timeRemaining) != seen[$]) seen.push_back(int'(timeRemaining));
        end
        n_cmp++; if (seen.size() != 4) begin n_err++; $display("FAIL notrunc_count: got %0d want 4", seen.size()); end
        for (int k = 0; k < seen.size() && k < 4; k++) begin
            n_cmp++; if (seen[k] != 4 - k) begin n_err++; $display("FAIL notrunc_seq[%0d]: got %0d want %0d", k, seen[k], 4 - k); end
        end
        ped_req_p = 1'b1;
        advance();
        ped_req_p = 1'b0;
        n_cmp++; if (StateFlag !== 2'd1 || timeRemaining !== 7'd3 || PhraseSel !== 2'd2) begin
            n_err++; $display("FAIL py_request: got %0d/%0d/%0d want 1/3/2", StateFlag, timeRemaining, PhraseSel);
        end
        for (int i = 0; i < 200 && StateFlag != 2'd2; i++) advance();
        n_cmp++; if (timeRemaining !== 7'd6 || PhraseSel !== 2'd1) begin n_err++; $display("FAIL py_to_sg: got %0d/%0d want 6/1", timeRemaining, PhraseSel); end
    endtask

    task automatic test_cfg_err();
        Tsv = 7'd0;
        for (int i = 0; i < 400 && StateFlag != 2'd3; i++) advance();
        for (int i = 0; i < 400 && StateFlag != 2'd2; i++) advance();
        n_cmp++; if (StateFlag !== 2'd2 || timeRemaining !== 7'd1 || PhraseSel !== 2'd3) begin
            n_err++; $display("FAIL tsv_zero: got %0d/%0d/%0d want 2/1/3", StateFlag, timeRemaining, PhraseSel);
        end
        Tsv = 7'd120;
        for (int i = 0; i < 400 && StateFlag != 2'd3; i++) advance();
        n_cmp++; if (PhraseSel !== 2'd1) begin n_err++; $display("FAIL err_clear_sy: got %0d want 1", PhraseSel); end
        for (int i = 0; i < 400 && StateFlag != 2'd2; i++) advance();
        n_cmp++; if (StateFlag !== 2'd2 || timeRemaining !== 7'd99 || PhraseSel !== 2'd3) begin
            n_err++; $display("FAIL tsv_big: got %0d/%0d/%0d want 2/99/3", StateFlag, timeRemaining, PhraseSel);
        end
        ped_req_s = 1'b1;
        advance();
        ped_req_s = 1'b0;
        Tsv = 7'd6;
        n_cmp++; if (timeRemaining !== 7'd5 || PhraseSel !== 2'd3) begin n_err++; $display("FAIL sg_trunc_err: got %0d/%0d want 5/3", timeRemaining, PhraseSel); end
        for (int i = 0; i < 400 && StateFlag != 2'd3; i++) advance();
        n_cmp++; if (PhraseSel !== 2'd2) begin n_err++; $display("FAIL sy_pending_s: got %0d want 2", PhraseSel); end
        for (int i = 0; i < 400 && StateFlag != 2'd0; i++) advance();
        n_cmp++; if (StateFlag !== 2'd0 || timeRemaining !== 7'd8 || PhraseSel !== 2'd0) begin
            n_err++; $display("FAIL pg_after_err: got %0d/%0d/%0d want 0/8/0", StateFlag, timeRemaining, PhraseSel);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        Tpv = 7'd11;
        for (int i = 0; i < 400; i++) begin
            if (StateFlag == 2'd3 && m_presc == TPS - 1) break;
            advance();
        end
        n_cmp++; if (StateFlag !== 2'd3) begin n_err++; $display("FAIL rst_mid_wait: got %0d want 3", StateFlag); end
        reset = 1'b0; ped_req_p = 1'b1; ped_req_s = 1'b1;
        advance();
        reset = 1'b1; ped_req_p = 1'b0; ped_req_s = 1'b0;
        n_cmp++; if (act_vec !== {2'd0, 2'd0, 7'd11, 3'b001, 3'b100, 2'b10, 2'b01}) begin
            n_err++; $display("FAIL rst_mid_vec: got %h want %h", act_vec, {2'd0, 2'd0, 7'd11, 3'b001, 3'b100, 2'b10, 2'b01});
        end
        n = 0;
        while (timeRemaining == 7'd11 && n < 50) begin advance(); n++; end
        n_cmp++; if (n != TPS) begin n_err++; $display("FAIL rst_mid_presc: got %0d want %0d", n, TPS); end
        n_cmp++; if (PhraseSel !== 2'd0) begin n_err++; $display("FAIL rst_mid_pending: got %0d want 0", PhraseSel); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            if (i % 60 == 0) begin
                int r;
                r = $urandom_range(0, 19); Tpv = (r < 2) ? 7'd0 : (r < 4) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(1, 9));
                r = $urandom_range(0, 19); Tsv = (r < 2) ? 7'd0 : (r < 4) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(1, 9));
                r = $urandom_range(0, 19); Ta  = (r < 2) ? 7'd0 : (r < 3) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(1, 5));
            end
            ped_req_p = ($urandom_range(0, 29) == 0);
            ped_req_s = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 399) != 0);
            advance();
            n_cmp++; if (act_vec !== exp_vec()) begin n_err++; $display("FAIL random cyc %0d: got %h want %h", i, act_vec, exp_vec()); end
        end
        reset = 1'b1; ped_req_p = 1'b0; ped_req_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_lamps();
        test_truncation();
        test_no_truncation();
        test_cfg_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
